izh_stim_state_rmw_ctrl: RTL and testbench

//  Read-modify-write sequencer for the Izhikevich stimulation-strength state fields in neuron SRAM.

---
 rtl/izh_stim_state_rmw_ctrl_pkg.sv | 28 ++
 rtl/izh_stim_state_rmw_ctrl.sv | 114 +++++++++++
 tb/tb_izh_stim_state_rmw_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/izh_stim_state_rmw_ctrl_pkg.sv
// izh_stim_state_rmw_ctrl_pkg: event encodings, FSM states and stim word layout
package izh_stim_state_rmw_ctrl_pkg;

    localparam int STIM_W = 12;

    typedef enum logic [1:0] {
        EVT_NONE = 2'b00,
        EVT_EXC  = 2'b01,
        EVT_INH  = 2'b10,
        EVT_TREF = 2'b11
    } evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_WRITE
    } state_t;

    // Stim word packing, MSB first: [11:10] inhexc_prev, [9:8] stim0_prev, [7:4] stim_str_tmp, [3:0] stim_str
    typedef struct packed {
        logic [1:0] inhexc_prev;
        logic [1:0] stim0_prev;
        logic [3:0] stim_str_tmp;
        logic [3:0] stim_str;
    } stim_word_t;

endpackage

// File: rtl/izh_stim_state_rmw_ctrl.sv
// izh_stim_state_rmw_ctrl: read-modify-write sequencer for the Izhikevich stim-strength fields in neuron SRAM
module izh_stim_state_rmw_ctrl
    import izh_stim_state_rmw_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int NEUR_N = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EVT_VALID,
    output logic              EVT_READY,
    input  logic [1:0]        EVT_TYPE,
    input  logic [ADDR_W-1:0] EVT_ADDR,
    output logic              SRAM_CS,
    output logic              SRAM_WE,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [STIM_W-1:0] SRAM_D,
    input  logic [STIM_W-1:0] SRAM_Q,
    output logic [3:0]        UPD_STIM_STR,
    output logic [3:0]        UPD_STIM_STR_TMP,
    output logic [1:0]        UPD_STIM0_PREV,
    output logic [1:0]        UPD_INHEXC_PREV,
    output logic              UPD_OVFL_EXC,
    output logic              UPD_OVFL_INH,
    output logic              UPD_EVENT_TREF,
    input  logic [STIM_W-1:0] UPD_NEXT,
    output logic              SWEEP_DONE
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NEUR_N - 1);

    state_t            state_q, state_d;
    evt_t              type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    stim_word_t        word_q, word_d;
    logic              done_q, done_d;

    // State, sampled event, sweep counter and captured fields; reset abandons any in-flight RMW
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            type_q  <= EVT_NONE;
            addr_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic and per-state SRAM / update-logic strobes
    always_comb begin
        state_d        = state_q;
        type_d         = type_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        word_d         = word_q;
        done_d         = 1'b0;
        SRAM_CS        = 1'b0;
        SRAM_WE        = 1'b0;
        UPD_OVFL_EXC   = 1'b0;
        UPD_OVFL_INH   = 1'b0;
        UPD_EVENT_TREF = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EVT_VALID) begin
                    type_d = evt_t'(EVT_TYPE);
                    addr_d = EVT_ADDR;
                    if (evt_t'(EVT_TYPE) == EVT_TREF) cnt_d = '0;
                    if (evt_t'(EVT_TYPE) != EVT_NONE) state_d = ST_READ;
                end
            end
            ST_READ: begin
                SRAM_CS = 1'b1;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                word_d  = SRAM_Q;
                state_d = ST_WRITE;
            end
            default: begin
                SRAM_CS        = 1'b1;
                SRAM_WE        = 1'b1;
                UPD_OVFL_EXC   = type_q == EVT_EXC;
                UPD_OVFL_INH   = type_q == EVT_INH;
                UPD_EVENT_TREF = type_q == EVT_TREF;
                if (type_q == EVT_TREF && cnt_q != LAST_ADDR) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_READ;
                end else begin
                    done_d  = type_q == EVT_TREF;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign EVT_READY        = state_q == ST_IDLE;
    assign SRAM_A           = type_q == EVT_TREF ? cnt_q : addr_q;
    assign SRAM_D           = UPD_NEXT;
    assign UPD_STIM_STR     = word_q.stim_str;
    assign UPD_STIM_STR_TMP = word_q.stim_str_tmp;
    assign UPD_STIM0_PREV   = word_q.stim0_prev;
    assign UPD_INHEXC_PREV  = word_q.inhexc_prev;
    assign SWEEP_DONE       = done_q;

endmodule

// File: tb/tb_izh_stim_state_rmw_ctrl.sv
// tb_izh_stim_state_rmw_ctrl: directed self-checking bench for the stim-state RMW sequencer
module tb_izh_stim_state_rmw_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EVT_VALID = 1'b0;
    logic        EVT_READY;
    logic [1:0]  EVT_TYPE = 2'b00;
    logic [7:0]  EVT_ADDR = 8'h00;
    logic        SRAM_CS, SRAM_WE;
    logic [7:0]  SRAM_A;
    logic [11:0] SRAM_D;
    logic [11:0] SRAM_Q = 12'h000;
    logic [3:0]  UPD_STIM_STR, UPD_STIM_STR_TMP;
    logic [1:0]  UPD_STIM0_PREV, UPD_INHEXC_PREV;
    logic        UPD_OVFL_EXC, UPD_OVFL_INH, UPD_EVENT_TREF;
    logic [11:0] UPD_NEXT = 12'h000;
    logic        SWEEP_DONE;

    logic [11:0] mem [256];
    int checks = 0;
    int errors = 0;

    izh_stim_state_rmw_ctrl #(.ADDR_W(8), .NEUR_N(4)) dut (
        .CLK(CLK), .RST(RST),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_TYPE(EVT_TYPE), .EVT_ADDR(EVT_ADDR),
        .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q),
        .UPD_STIM_STR(UPD_STIM_STR), .UPD_STIM_STR_TMP(UPD_STIM_STR_TMP),
        .UPD_STIM0_PREV(UPD_STIM0_PREV), .UPD_INHEXC_PREV(UPD_INHEXC_PREV),
        .UPD_OVFL_EXC(UPD_OVFL_EXC), .UPD_OVFL_INH(UPD_OVFL_INH), .UPD_EVENT_TREF(UPD_EVENT_TREF),
        .UPD_NEXT(UPD_NEXT), .SWEEP_DONE(SWEEP_DONE)
    );

    always #5 CLK = ~CLK;

    // Synchronous SRAM model: read data one cycle after a read select
    always @(posedge CLK) begin
        if (SRAM_CS && !SRAM_WE) SRAM_Q <= mem[SRAM_A];
        if (SRAM_CS && SRAM_WE) mem[SRAM_A] <= SRAM_D;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        if (1) begin
            checks++;
            if (EVT_READY !== 1'b1 || SRAM_CS !== 1'b0 || SRAM_WE !== 1'b0 || SWEEP_DONE !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl: ready=%b cs=%b we=%b done=%b, want 1 0 0 0", EVT_READY, SRAM_CS, SRAM_WE, SWEEP_DONE);
            end
        end
        checks++;
        if ({UPD_INHEXC_PREV, UPD_STIM0_PREV, UPD_STIM_STR_TMP, UPD_STIM_STR} !== 12'h000 ||
            {UPD_OVFL_EXC, UPD_OVFL_INH, UPD_EVENT_TREF} !== 3'b000) begin
            errors++;
            $display("FAIL reset_upd: fields=%h flags=%b, want 000 000",
                     {UPD_INHEXC_PREV, UPD_STIM0_PREV, UPD_STIM_STR_TMP, UPD_STIM_STR},
                     {UPD_OVFL_EXC, UPD_OVFL_INH, UPD_EVENT_TREF});
        end
    endtask

    task automatic test_exc();
        mem[5] = 12'h000;
        UPD_NEXT = 12'h010;
        EVT_VALID = 1'b1; EVT_TYPE = 2'b01; EVT_ADDR = 8'h05;
        checks++;
        if (EVT_READY !== 1'b1) begin errors++; $display("FAIL exc_accept: ready=%b want 1", EVT_READY); end
        tick();
        EVT_VALID = 1'b0;
        checks++;
        if ({SRAM_CS, SRAM_WE, SRAM_A} !== {2'b10, 8'h05} || EVT_READY !== 1'b0) begin
            errors++; $display("FAIL exc_read: cs=%b we=%b a=%h ready=%b want 1 0 05 0", SRAM_CS, SRAM_WE, SRAM_A, EVT_READY);
        end
        tick();
        checks++;
        if (SRAM_CS !== 1'b0 || UPD_OVFL_EXC !== 1'b0) begin
            errors++; $display("FAIL exc_latch: cs=%b exc=%b want 0 0", SRAM_CS, UPD_OVFL_EXC);
        end
        tick();
        checks++;
        if ({SRAM_CS, SRAM_WE, SRAM_A, SRAM_D} !== {2'b11, 8'h05, 12'h010} ||
            {UPD_OVFL_EXC, UPD_OVFL_INH, UPD_EVENT_TREF} !== 3'b100) begin
            errors++;
            $display("FAIL exc_write: cs=%b we=%b a=%h d=%h flags=%b want 1 1 05 010 100",
                     SRAM_CS, SRAM_WE, SRAM_A, SRAM_D, {UPD_OVFL_EXC, UPD_OVFL_INH, UPD_EVENT_TREF});
        end
        tick();
        checks++;
        if (EVT_READY !== 1'b1 || mem[5] !== 12'h010 || SRAM_CS !== 1'b0) begin
            errors++; $display("FAIL exc_done: ready=%b mem5=%h cs=%b want 1 010 0", EVT_READY, mem[5], SRAM_CS);
        end
    endtask

    task automatic test_inh();
        mem[8'h80] = 12'h090;
        UPD_NEXT = 12'h4A3;
        EVT_VALID = 1'b1; EVT_TYPE = 2'b10; EVT_ADDR = 8'h80;
        tick();
        EVT_VALID = 1'b0;
        tick();
        checks++;
        if (UPD_OVFL_INH !== 1'b0) begin errors++; $display("FAIL inh_latch_flag: inh=%b want 0", UPD_OVFL_INH); end
        tick();
        checks++;
        if (UPD_STIM_STR_TMP !== 4'h9 || UPD_STIM_STR !== 4'h0 || UPD_STIM0_PREV !== 2'd0 || UPD_INHEXC_PREV !== 2'd0) begin
            errors++; $display("FAIL inh_fields: tmp=%h str=%h s0=%h ie=%h want 9 0 0 0",
                               UPD_STIM_STR_TMP, UPD_STIM_STR, UPD_STIM0_PREV, UPD_INHEXC_PREV);
        end
        checks++;
        if ({UPD_OVFL_EXC, UPD_OVFL_INH, UPD_EVENT_TREF} !== 3'b010 || SRAM_A !== 8'h80) begin
            errors++; $display("FAIL inh_write: flags=%b a=%h want 010 80", {UPD_OVFL_EXC, UPD_OVFL_INH, UPD_EVENT_TREF}, SRAM_A);
        end
        tick();
        checks++;
        if (UPD_OVFL_INH !== 1'b0 || mem[8'h80] !== 12'h4A3) begin
            errors++; $display("FAIL inh_after: inh=%b mem=%h want 0 4a3", UPD_OVFL_INH, mem[8'h80]);
        end
    endtask

    task automatic test_tref_sweep();
        int bad = 0;
        int dones = 0;
        for (int i = 0; i < 4; i++) mem[i] = 12'(12'h100 * (i + 1) + 12'h0E1);
        UPD_NEXT = 12'h5A5;
        EVT_VALID = 1'b1; EVT_TYPE = 2'b11; EVT_ADDR = 8'h77;
        tick();
        EVT_VALID = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            int ph = (k - 1) % 3;
            logic [7:0] ea = 8'((k - 1) / 3);
            if (EVT_READY !== 1'b0) bad++;
            if (SWEEP_DONE) dones++;
            if (ph == 0 && {SRAM_CS, SRAM_WE, SRAM_A, UPD_EVENT_TREF} !== {2'b10, ea, 1'b0}) bad++;
            if (ph == 1 && {SRAM_CS, UPD_EVENT_TREF} !== 2'b00) bad++;
            if (ph == 2 && {SRAM_CS, SRAM_WE, SRAM_A, UPD_EVENT_TREF} !== {2'b11, ea, 1'b1}) bad++;
            if (ph == 2 && {UPD_INHEXC_PREV, UPD_STIM0_PREV, UPD_STIM_STR_TMP, UPD_STIM_STR} !== 12'(12'h100 * (ea + 1) + 12'h0E1)) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || dones != 0) begin
            errors++; $display("FAIL tref_sequence: %0d bad cycles, %0d early done pulses, want 0 0", bad, dones);
        end
        checks++;
        if (SWEEP_DONE !== 1'b1 || EVT_READY !== 1'b1) begin
            errors++; $display("FAIL tref_done_pulse: done=%b ready=%b want 1 1", SWEEP_DONE, EVT_READY);
        end
        tick();
        checks++;
        if (SWEEP_DONE !== 1'b0) begin errors++; $display("FAIL tref_done_once: done=%b want 0", SWEEP_DONE); end
        checks++;
        if (mem[0] !== 12'h5A5 || mem[1] !== 12'h5A5 || mem[2] !== 12'h5A5 || mem[3] !== 12'h5A5 || mem[4] !== 12'h000) begin
            errors++; $display("FAIL tref_mem: %h %h %h %h %h want 5a5 x4 then 000", mem[0], mem[1], mem[2], mem[3], mem[4]);
        end
    endtask

    task automatic test_none();
        int acc = 0;
        int cs = 0;
        EVT_VALID = 1'b1; EVT_TYPE = 2'b00; EVT_ADDR = 8'h05;
        for (int k = 0; k < 3; k++) begin
            if (EVT_READY === 1'b1) acc++;
            if (SRAM_CS !== 1'b0) cs++;
            tick();
        end
        EVT_VALID = 1'b0;
        if (SRAM_CS !== 1'b0) cs++;
        checks++;
        if (acc != 3 || cs != 0 || EVT_READY !== 1'b1) begin
            errors++; $display("FAIL none_drop: acceptances=%0d cs_cycles=%0d ready=%b want 3 0 1", acc, cs, EVT_READY);
        end
    endtask

    task automatic test_reset_mid();
        mem[8'h10] = 12'hFFF;
        UPD_NEXT = 12'h123;
        EVT_VALID = 1'b1; EVT_TYPE = 2'b01; EVT_ADDR = 8'h10;
        tick();
        EVT_VALID = 1'b0;
        tick();
        RST = 1'b1;
        #1;
        checks++;
        if (SRAM_CS !== 1'b0 || SRAM_WE !== 1'b0 || EVT_READY !== 1'b1) begin
            errors++; $display("FAIL rst_mid_immediate: cs=%b we=%b ready=%b want 0 0 1", SRAM_CS, SRAM_WE, EVT_READY);
        end
        tick();
        RST = 1'b0;
        tick();
        tick();
        checks++;
        if (mem[8'h10] !== 12'hFFF || EVT_READY !== 1'b1 || SRAM_CS !== 1'b0 ||
            {UPD_INHEXC_PREV, UPD_STIM0_PREV, UPD_STIM_STR_TMP, UPD_STIM_STR} !== 12'h000) begin
            errors++; $display("FAIL rst_mid_after: mem=%h ready=%b cs=%b fields=%h want fff 1 0 000", mem[8'h10], EVT_READY, SRAM_CS,
                               {UPD_INHEXC_PREV, UPD_STIM0_PREV, UPD_STIM_STR_TMP, UPD_STIM_STR});
        end
    endtask

    task automatic test_back_to_back();
        mem[8'h20] = 12'h000;
        mem[8'h21] = 12'h111;
        UPD_NEXT = 12'h2AA;
        EVT_VALID = 1'b1; EVT_TYPE = 2'b01; EVT_ADDR = 8'h20;
        tick();
        EVT_TYPE = 2'b10; EVT_ADDR = 8'h21;
        checks++;
        if (SRAM_A !== 8'h20 || SRAM_CS !== 1'b1) begin errors++; $display("FAIL b2b_read1: a=%h cs=%b want 20 1", SRAM_A, SRAM_CS); end
        tick();
        tick();
        checks++;
        if (SRAM_A !== 8'h20 || SRAM_WE !== 1'b1 || {UPD_OVFL_EXC, UPD_OVFL_INH} !== 2'b10) begin
            errors++; $display("FAIL b2b_write1: a=%h we=%b exc_inh=%b want 20 1 10", SRAM_A, SRAM_WE, {UPD_OVFL_EXC, UPD_OVFL_INH});
        end
        tick();
        checks++;
        if (EVT_READY !== 1'b1 || mem[8'h20] !== 12'h2AA || mem[8'h21] !== 12'h111) begin
            errors++; $display("FAIL b2b_cycle4: ready=%b m20=%h m21=%h want 1 2aa 111", EVT_READY, mem[8'h20], mem[8'h21]);
        end
        tick();
        EVT_VALID = 1'b0;
        checks++;
        if ({SRAM_CS, SRAM_WE, SRAM_A} !== {2'b10, 8'h21}) begin
            errors++; $display("FAIL b2b_read2: cs=%b we=%b a=%h want 1 0 21", SRAM_CS, SRAM_WE, SRAM_A);
        end
        tick();
        tick();
        checks++;
        if ({UPD_OVFL_EXC, UPD_OVFL_INH} !== 2'b01 || UPD_STIM_STR !== 4'h1 || UPD_STIM_STR_TMP !== 4'h1) begin
            errors++; $display("FAIL b2b_write2: exc_inh=%b str=%h tmp=%h want 01 1 1", {UPD_OVFL_EXC, UPD_OVFL_INH}, UPD_STIM_STR, UPD_STIM_STR_TMP);
        end
        tick();
        checks++;
        if (EVT_READY !== 1'b1 || mem[8'h21] !== 12'h2AA) begin
            errors++; $display("FAIL b2b_done: ready=%b m21=%h want 1 2aa", EVT_READY, mem[8'h21]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        tick();
        tick();
        RST = 1'b0;
        test_reset();
        tick();
        test_exc();
        test_inh();
        test_tref_sweep();
        test_none();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
